// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the registered ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU and whoever drives it.
interface alu_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;

  modport master (output A, B, ALU_Sel, input ALU_Out, CarryOut);
  modport slave  (input A, B, ALU_Sel, output ALU_Out, CarryOut);

endinterface

// File: rtl/alu_datapath.sv
// Combinational opcode decode: next result and next carry/borrow/error flag.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  // Operation decode; every op fully assigns result and flag.
  always_comb begin
    w_sum    = {(WIDTH+1){1'b0}};
    w_prod   = {(2*WIDTH){1'b0}};
    o_result = {WIDTH{1'b0}};
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_result = i_a - i_b;
        o_carry  = (i_a < i_b);
      end
      OP_MUL: begin
        w_prod   = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
        o_result = w_prod[WIDTH-1:0];
        o_carry  = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        // Divide by zero saturates and raises the flag as an error indicator.
        if (i_b == {WIDTH{1'b0}}) begin
          o_result = {WIDTH{1'b1}};
          o_carry  = 1'b1;
        end else begin
          o_result = i_a / i_b;
          o_carry  = 1'b0;
        end
      end
      OP_SHL: begin
        o_result = {i_a[WIDTH-2:0], 1'b0};
        o_carry  = i_a[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_carry  = i_a[0];
      end
      OP_ROL:  o_result = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      OP_ROR:  o_result = {i_a[0], i_a[WIDTH-1:1]};
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_NAND: o_result = ~(i_a & i_b);
      OP_XNOR: o_result = ~(i_a ^ i_b);
      OP_GT:   o_result = {{(WIDTH-1){1'b0}}, (i_a > i_b)};
      OP_EQ:   o_result = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
      default: begin
        o_result = {WIDTH{1'b0}};
        o_carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: one-cycle latency, synchronous active-low reset, no enable.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clock,
  input  logic  reset,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  alu_op_e          w_op;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;

  assign w_op = alu_op_e'(bus.ALU_Sel);

  alu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_op     (w_op),
    .o_result (w_result),
    .o_carry  (w_carry)
  );

  // Output register; reset overrides whatever operation is presented.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_out   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_result;
      r_carry <= w_carry;
    end
  end

  assign bus.ALU_Out  = r_out;
  assign bus.CarryOut = r_carry;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench: directed vectors plus randomized stream against a behavioural model.
module tb_alu_unit;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  alu_if #(.WIDTH(W)) bus ();

  alu_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: opcode semantics expressed with plain integer arithmetic.
  function automatic void model(input int a, input int b, input int sel, output int r, output int c);
    r = 0;
    c = 0;
    case (sel)
      0:  begin r = (a + b) & MASK; c = ((a + b) > MASK) ? 1 : 0; end
      1:  begin r = (a - b) & MASK; c = (a < b) ? 1 : 0; end
      2:  begin r = (a * b) & MASK; c = ((a * b) > MASK) ? 1 : 0; end
      3:  begin
            if (b == 0) begin r = MASK; c = 1; end
            else        begin r = a / b; c = 0; end
          end
      4:  begin r = (a * 2) & MASK; c = (a >= (1 << (W - 1))) ? 1 : 0; end
      5:  begin r = a / 2; c = a % 2; end
      6:  r = ((a * 2) & MASK) + (a / (1 << (W - 1)));
      7:  r = (a / 2) + ((a % 2) * (1 << (W - 1)));
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = (~(a | b)) & MASK;
      12: r = (~(a & b)) & MASK;
      13: r = (~(a ^ b)) & MASK;
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: begin r = 0; c = 0; end
    endcase
  endfunction

  int exp_out;
  int exp_c;
  bit exp_valid = 1'b0;

  // Predict the register contents from the inputs present at each rising edge.
  always @(posedge clock) begin
    if (reset === 1'b0) begin
      exp_out = 0;
      exp_c   = 0;
    end else begin
      model(int'(bus.A), int'(bus.B), int'(bus.ALU_Sel), exp_out, exp_c);
    end
    exp_valid = 1'b1;
  end

  // Compare the DUT against the prediction midway through every cycle.
  always @(negedge clock) begin
    if (exp_valid) begin
      checks++;
      if (bus.ALU_Out !== W'(exp_out) || bus.CarryOut !== 1'(exp_c)) begin
        failures++;
        $display("FAIL model_cmp t=%0t got out=%0d c=%0b expected out=%0d c=%0d",
                 $time, bus.ALU_Out, bus.CarryOut, exp_out, exp_c);
      end
    end
  end

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s, input logic rst);
    bus.A       = a;
    bus.B       = b;
    bus.ALU_Sel = s;
    reset       = rst;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] exp_r, input logic exp_cf);
    checks++;
    if (bus.ALU_Out !== exp_r || bus.CarryOut !== exp_cf) begin
      failures++;
      $display("FAIL %s got out=%0d c=%0b expected out=%0d c=%0b",
               name, bus.ALU_Out, bus.CarryOut, exp_r, exp_cf);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic [W-1:0] r;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mr;
    int mc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rs;
    logic         rr;
    checks   = 0;
    failures = 0;
    reset       = 1'b0;
    bus.A       = 8'd10;
    bus.B       = 8'd5;
    bus.ALU_Sel = 4'h0;

    vecs.push_back('{8'd10,  8'd5,   4'h0, 8'd15,  1'b0});
    vecs.push_back('{8'd20,  8'd15,  4'h0, 8'd35,  1'b0});
    vecs.push_back('{8'd200, 8'd100, 4'h0, 8'd44,  1'b1});
    vecs.push_back('{8'd15,  8'd5,   4'h1, 8'd10,  1'b0});
    vecs.push_back('{8'd50,  8'd30,  4'h1, 8'd20,  1'b0});
    vecs.push_back('{8'd5,   8'd10,  4'h1, 8'd251, 1'b1});
    vecs.push_back('{8'd3,   8'd2,   4'h2, 8'd6,   1'b0});
    vecs.push_back('{8'd4,   8'd5,   4'h2, 8'd20,  1'b0});
    vecs.push_back('{8'd20,  8'd20,  4'h2, 8'd144, 1'b1});
    vecs.push_back('{8'd20,  8'd4,   4'h3, 8'd5,   1'b0});
    vecs.push_back('{8'd30,  8'd5,   4'h3, 8'd6,   1'b0});
    vecs.push_back('{8'd7,   8'd0,   4'h3, 8'd255, 1'b1});
    vecs.push_back('{8'h81,  8'hA5,  4'h4, 8'h02,  1'b1});
    vecs.push_back('{8'h81,  8'h5A,  4'h5, 8'h40,  1'b1});
    vecs.push_back('{8'h81,  8'hFF,  4'h6, 8'h03,  1'b0});
    vecs.push_back('{8'h81,  8'h00,  4'h7, 8'hC0,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  4'h8, 8'h30,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  4'h9, 8'hFC,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  4'hA, 8'hCC,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  4'hB, 8'h03,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  4'hC, 8'hCF,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  4'hD, 8'h33,  1'b0});
    vecs.push_back('{8'd9,   8'd3,   4'hE, 8'd1,   1'b0});
    vecs.push_back('{8'd3,   8'd9,   4'hE, 8'd0,   1'b0});
    vecs.push_back('{8'd7,   8'd7,   4'hF, 8'd1,   1'b0});
    vecs.push_back('{8'd7,   8'd8,   4'hF, 8'd0,   1'b0});

    // Pin the model itself against the hand-computed table.
    foreach (vecs[i]) begin
      model(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].s), mr, mc);
      checks++;
      if (mr != int'(vecs[i].r) || mc != int'(vecs[i].c)) begin
        failures++;
        $display("FAIL model_pin[%0d] got r=%0d c=%0d expected r=%0d c=%0b",
                 i, mr, mc, vecs[i].r, vecs[i].c);
      end
    end

    // Reset held for two edges with an ADD presented, then released.
    @(posedge clock);
    @(negedge clock);
    check_lit("reset_edge1", 8'd0, 1'b0);
    apply(8'd10, 8'd5, 4'h0, 1'b0);
    check_lit("reset_edge2", 8'd0, 1'b0);
    apply(8'd10, 8'd5, 4'h0, 1'b1);
    check_lit("reset_release", 8'd15, 1'b0);

    // Directed table, back to back with the opcode changing every cycle.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1);
      check_lit($sformatf("vec%0d_op%0h", i, vecs[i].s), vecs[i].r, vecs[i].c);
    end

    // Reset in the middle of a MUL stream, then resume.
    apply(8'd3, 8'd2, 4'h2, 1'b1);
    check_lit("mul_stream_a", 8'd6, 1'b0);
    apply(8'd20, 8'd20, 4'h2, 1'b1);
    check_lit("mul_stream_b", 8'd144, 1'b1);
    apply(8'd4, 8'd5, 4'h2, 1'b0);
    check_lit("mul_stream_rst", 8'd0, 1'b0);
    apply(8'd4, 8'd5, 4'h2, 1'b1);
    check_lit("mul_stream_resume", 8'd20, 1'b0);
    apply(8'd16, 8'd16, 4'h2, 1'b1);
    check_lit("mul_stream_ovf", 8'd0, 1'b1);

    // Randomized stream with occasional zero/equal operands and stray resets.
    for (int n = 0; n < 400; n++) begin
      ra = W'($urandom_range(0, MASK));
      rb = W'($urandom_range(0, MASK));
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
      if ($urandom_range(0, 7) == 0) rb = ra;
      rs = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 19) != 0);
      apply(ra, rb, rs, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered 8-bit arithmetic/logic unit with 16 operations selected by a 4-bit opcode.
- Produces a data result and a carry/borrow/overflow flag, both registered one clock after the operands.
- Used as a standalone datapath block and as the primary target of the verification flow.

Parameters:
- WIDTH, 8, operand and result width in bits; all rules below are written for WIDTH=8 and scale with it.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- ALU_Sel  input  4  operation select.
- ALU_Out  output  WIDTH  registered result.
- CarryOut  output  1  registered carry/borrow/overflow flag.

Behaviour:
- Reset: a rising edge with reset==0 sets ALU_Out=0 and CarryOut=0. Reset has priority over any operation, including one mid-stream.
- Normal edge (reset==1): the combinational result of A, B and ALU_Sel sampled at that edge is loaded into ALU_Out and CarryOut.
  - Latency is 1 cycle. There is no handshake; a new operation is accepted every cycle.
- Opcodes (result -> CarryOut). Unsigned arithmetic; results truncated to WIDTH.
  - 0000 ADD: A+B mod 2^W -> bit W of the full sum.
  - 0001 SUB: A-B mod 2^W -> 1 if A<B (borrow), else 0.
  - 0010 MUL: low W bits of A*B -> 1 if the high W bits are nonzero.
  - 0011 DIV: A/B truncated toward zero -> 0.
    - B==0: result all ones (255), CarryOut=1 as the divide-error flag.
  - 0100 SHL: A<<1 -> A[W-1].
  - 0101 SHR: A>>1 (logical) -> A[0].
  - 0110 ROL: {A[W-2:0],A[W-1]} -> 0.
  - 0111 ROR: {A[0],A[W-1:1]} -> 0.
  - 1000 AND: A&B -> 0.
  - 1001 OR: A|B -> 0.
  - 1010 XOR: A^B -> 0.
  - 1011 NOR: ~(A|B) -> 0.
  - 1100 NAND: ~(A&B) -> 0.
  - 1101 XNOR: ~(A^B) -> 0.
  - 1110 GT: 1 if A>B else 0 -> 0.
  - 1111 EQ: 1 if A==B else 0 -> 0.
- B is ignored by the shift and rotate ops.
- No X propagation from an unused operand. Outputs are never X after the first reset edge.
- Outputs hold their values only until the next edge; there is no enable.

Decomposition:
- Package alu_pkg:
  - WIDTH default constant.
  - alu_op_e enum for the 16 opcodes (OP_ADD … OP_EQ, 4-bit).
- Sub-module alu_datapath: purely combinational opcode decode and arithmetic, producing next result and next carry.
- alu_unit instantiates alu_datapath and holds the output register with synchronous active-low reset.

Test Plan:
- Reset: reset=0 for 2 edges with A=10, B=5, ADD -> ALU_Out=0, CarryOut=0. Release reset -> one edge later ALU_Out=15, CarryOut=0.
- ADD/SUB:
  - 10+5 -> 15/0.
  - 20+15 -> 35/0.
  - 200+100 -> 44/1.
  - 15-5 -> 10/0.
  - 50-30 -> 20/0.
  - 5-10 -> 251/1.
- MUL/DIV:
  - 3*2 -> 6/0.
  - 4*5 -> 20/0.
  - 20*20 -> 144/1.
  - 20/4 -> 5/0.
  - 30/5 -> 6/0.
  - 7/0 -> 255/1.
- Shift/rotate/logic:
  - A=0x81: SHL -> 0x02/1.
  - A=0x81: SHR -> 0x40/1.
  - A=0x81: ROL -> 0x03/0.
  - A=0x81: ROR -> 0xC0/0.
  - A=0xF0, B=0x3C: AND -> 0x30, OR -> 0xFC, XOR -> 0xCC, NOR -> 0x03, NAND -> 0xCF, XNOR -> 0x33.
- Compare:
  - GT(9,3) -> 1.
  - GT(3,9) -> 0.
  - EQ(7,7) -> 1.
  - EQ(7,8) -> 0.
- Back-to-back and mid-stream reset:
  - Change the opcode every cycle -> each result appears exactly one edge after its inputs.
  - Assert reset during a MUL stream -> outputs 0 on that edge.
  - Deassert reset -> the stream resumes with 1-cycle latency.
